// File: rtl/cnn_rd_arbiter.sv
// cnn_rd_arbiter
//
// Purpose:
//   Shares the AXI4 AR/R channel pair of the CNN AXI master between two burst
//   requesters: port 0 (IFM tile fetch) and port 1 (weight fetch). Burst
//   requests are arbitrated onto AR one at a time. The granted port number is
//   pushed into an in-order tag FIFO, and each returning R beat is steered to
//   the port at the FIFO head.
//
// Build option:
//   RD_ARB_PRIORITY_EN  defined   -> fixed priority, port 0 wins when both are valid
//                       undefined -> round-robin (default)
//
// Ports:
//   ACLK, ARESETN                     clock, asynchronous active-low reset
//   reqN_valid/ready/addr/len         burst request handshake per port (N = 0,1)
//   rdN_data/valid/ready/last         beat delivery to requester N
//   M_AXI_AR*                         AXI4 read-address channel (master side)
//   M_AXI_R*                          AXI4 read-data channel (master side)
//   outstanding                       tag FIFO occupancy (accepted, not yet completed bursts)
//   rd_err                            sticky error: bad RRESP or a beat arriving with no owner
//   err_clr                           clears rd_err (a new error in the same cycle wins)
//   idle                              no AR pending and no burst outstanding
module cnn_rd_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int AXI_WIDTH       = 256,
    parameter int LEN_WIDTH       = 8,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [LEN_WIDTH-1:0]  req0_len,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [LEN_WIDTH-1:0]  req1_len,

    output logic [AXI_WIDTH-1:0]  rd0_data,
    output logic                  rd0_valid,
    input  logic                  rd0_ready,
    output logic                  rd0_last,

    output logic [AXI_WIDTH-1:0]  rd1_data,
    output logic                  rd1_valid,
    input  logic                  rd1_ready,
    output logic                  rd1_last,

    output logic [ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [LEN_WIDTH-1:0]  M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,

    input  logic [AXI_WIDTH-1:0]  M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,

    output logic [CW-1:0]         outstanding,
    output logic                  rd_err,
    input  logic                  err_clr,
    output logic                  idle
);

    localparam int SIZE_LOG2 = $clog2(AXI_WIDTH / 8);
    localparam int PW        = $clog2(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'((1 << SIZE_LOG2) - 1));

    typedef enum logic {
        AR_IDLE,
        AR_ISSUE
    } ar_state_t;

    ar_state_t             state_q;
    ar_state_t             state_d;

    logic                  grant;
    logic                  room;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [LEN_WIDTH-1:0]  arlen_q;

    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  tag_mem [MAX_OUTSTANDING];
    logic                  fifo_empty;
    logic                  head;
    logic                  push;
    logic                  pop;

    logic                  r_hs;
    logic                  stray;
    logic                  bad_beat;
    logic                  rd_err_q;

    // Constant AR attributes: a single ID so the slave returns bursts in order,
    // full-width beats and incrementing bursts.
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARSIZE  = 3'(SIZE_LOG2);
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = arlen_q;

`ifdef RD_ARB_PRIORITY_EN
    // Fixed priority: port 1 is only chosen when port 0 has nothing to ask for.
    always_comb begin
        grant = 1'b0;
        if (!req0_valid && req1_valid) begin
            grant = 1'b1;
        end
    end
`else
    logic last_grant_q;

    // Round-robin: a lone requester always wins; on a tie the port that did
    // not win last time gets the slot.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Remember who won the most recent accepted request. Resetting to 1 makes
    // port 0 the winner of the very first tie.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant;
        end
    end
`endif

    // A request can only be taken while no AR is in flight and the tag FIFO
    // still has room, so the FIFO can never overflow. accept is built from
    // inputs and state only, which keeps it out of the FSM process.
    assign room     = (count_q < CW'(MAX_OUTSTANDING));
    assign accept   = (state_q == AR_IDLE) && room && (grant ? req1_valid : req0_valid);
    assign sel_addr = grant ? req1_addr : req0_addr;
    assign sel_len  = grant ? req1_len  : req0_len;

    // AR state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= AR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // AR next-state and handshake outputs. Ready goes only to the granted
    // port; ARVALID is held in AR_ISSUE until the slave takes the address.
    always_comb begin
        state_d       = state_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        M_AXI_ARVALID = 1'b0;
        case (state_q)
            AR_IDLE: begin
                req0_ready = room && !grant;
                req1_ready = room && grant;
                if (accept) begin
                    state_d = AR_ISSUE;
                end
            end
            AR_ISSUE: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    state_d = AR_IDLE;
                end
            end
            default: begin
                state_d = AR_IDLE;
            end
        endcase
    end

    // Latch the accepted burst. The address is aligned down to a full beat so
    // the slave never sees a narrow first transfer. Values only change on
    // accept, which keeps them stable while ARVALID waits for ARREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            araddr_q <= '0;
            arlen_q  <= '0;
        end else if (accept) begin
            araddr_q <= sel_addr & ADDR_MASK;
            arlen_q  <= sel_len;
        end
    end

    // Tag FIFO control: push the winning port on accept, pop on the final beat
    // of a burst. Push and pop together leave the occupancy unchanged.
    assign push       = accept;
    assign r_hs       = M_AXI_RVALID && M_AXI_RREADY;
    assign pop        = r_hs && M_AXI_RLAST;
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem[rd_ptr_q];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read while the FIFO is
    // non-empty, and every such entry was written after reset.
    always_ff @(posedge ACLK) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= grant;
        end
    end

    // R steering is purely combinational so a beat flows through with no
    // added latency. Only the head owner sees data/valid/last; the other port
    // is held at zero. With no burst outstanding RREADY stays low so a stray
    // beat is never swallowed.
    always_comb begin
        rd0_data     = '0;
        rd0_valid    = 1'b0;
        rd0_last     = 1'b0;
        rd1_data     = '0;
        rd1_valid    = 1'b0;
        rd1_last     = 1'b0;
        M_AXI_RREADY = 1'b0;
        if (!fifo_empty) begin
            if (head) begin
                rd1_data     = M_AXI_RDATA;
                rd1_valid    = M_AXI_RVALID;
                rd1_last     = M_AXI_RLAST;
                M_AXI_RREADY = rd1_ready;
            end else begin
                rd0_data     = M_AXI_RDATA;
                rd0_valid    = M_AXI_RVALID;
                rd0_last     = M_AXI_RLAST;
                M_AXI_RREADY = rd0_ready;
            end
        end
    end

    // Sticky error flag. A consumed beat with a non-OKAY response, or a beat
    // presented while nothing is outstanding, sets it. Setting beats clearing
    // so an error landing on the clear cycle is not lost.
    assign stray    = M_AXI_RVALID && fifo_empty;
    assign bad_beat = r_hs && (M_AXI_RRESP != 2'b00);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_err_q <= 1'b0;
        end else if (stray || bad_beat) begin
            rd_err_q <= 1'b1;
        end else if (err_clr) begin
            rd_err_q <= 1'b0;
        end
    end

    assign rd_err      = rd_err_q;
    assign outstanding = count_q;
    assign idle        = (state_q == AR_IDLE) && fifo_empty;

endmodule

// File: tb/tb_cnn_rd_arbiter.sv
`timescale 1ns/1ps
module tb_cnn_rd_arbiter;

    localparam int ADDR_WIDTH      = 32;
    localparam int AXI_WIDTH       = 256;
    localparam int LEN_WIDTH       = 8;
    localparam int ID_WIDTH        = 4;
    localparam int MAX_OUTSTANDING = 4;
    localparam int CW              = $clog2(MAX_OUTSTANDING + 1);

    logic                  ACLK;
    logic                  ARESETN;
    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [LEN_WIDTH-1:0]  req0_len;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [LEN_WIDTH-1:0]  req1_len;
    logic [AXI_WIDTH-1:0]  rd0_data;
    logic                  rd0_valid;
    logic                  rd0_ready;
    logic                  rd0_last;
    logic [AXI_WIDTH-1:0]  rd1_data;
    logic                  rd1_valid;
    logic                  rd1_ready;
    logic                  rd1_last;
    logic [ID_WIDTH-1:0]   M_AXI_ARID;
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [LEN_WIDTH-1:0]  M_AXI_ARLEN;
    logic [2:0]            M_AXI_ARSIZE;
    logic [1:0]            M_AXI_ARBURST;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [AXI_WIDTH-1:0]  M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RLAST;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;
    logic [CW-1:0]         outstanding;
    logic                  rd_err;
    logic                  err_clr;
    logic                  idle;

    int   checks = 0;
    int   errors = 0;
    logic exp_last;
    logic exp_q[$];
    logic g;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  resp;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    cnn_rd_arbiter dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_addr     (req0_addr),
        .req0_len      (req0_len),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_addr     (req1_addr),
        .req1_len      (req1_len),
        .rd0_data      (rd0_data),
        .rd0_valid     (rd0_valid),
        .rd0_ready     (rd0_ready),
        .rd0_last      (rd0_last),
        .rd1_data      (rd1_data),
        .rd1_valid     (rd1_valid),
        .rd1_ready     (rd1_ready),
        .rd1_last      (rd1_last),
        .M_AXI_ARID    (M_AXI_ARID),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARLEN   (M_AXI_ARLEN),
        .M_AXI_ARSIZE  (M_AXI_ARSIZE),
        .M_AXI_ARBURST (M_AXI_ARBURST),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RLAST   (M_AXI_RLAST),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .outstanding   (outstanding),
        .rd_err        (rd_err),
        .err_clr       (err_clr),
        .idle          (idle)
    );

    // 100 MHz clock.
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Hard stop in case the bench ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: count it, report a failure with both values.
    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Distinct per-port, per-beat data pattern.
    function automatic logic [255:0] beatData(input logic port, input int idx);
        logic [255:0] d;
        d          = '0;
        d[255:248] = port ? 8'hB1 : 8'hA0;
        d[127:96]  = ~idx;
        d[31:0]    = idx;
        return d;
    endfunction

    // Expected winner when both ports are requesting.
    function automatic logic expGrant();
`ifdef RD_ARB_PRIORITY_EN
        return 1'b0;
`else
        return ~exp_last;
`endif
    endfunction

    // Slave returns one full burst to the given port with immediate readiness;
    // each beat must land on that port only, with last on the final beat.
    task automatic serveBurst(input logic port, input logic [7:0] len, input logic [1:0] resp, input string tag);
        for (int b = 0; b <= int'(len); b++) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = beatData(port, b);
            M_AXI_RRESP  = resp;
            M_AXI_RLAST  = (b == int'(len));
            #1;
            checkOutput({tag, "_rvalid_own"},  port ? rd1_valid : rd0_valid, 1);
            checkOutput({tag, "_rdata_own"},   port ? rd1_data  : rd0_data,  beatData(port, b));
            checkOutput({tag, "_rlast_own"},   port ? rd1_last  : rd0_last,  b == int'(len));
            checkOutput({tag, "_rvalid_oth"},  port ? rd0_valid : rd1_valid, 0);
            checkOutput({tag, "_rdata_oth"},   port ? rd0_data  : rd1_data,  0);
            checkOutput({tag, "_rready"},      M_AXI_RREADY, 1);
            tick();
        end
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        M_AXI_RRESP  = 2'b00;
    endtask

    // Single-requester burst with an immediately ready AR slave.
    task automatic issueOne(input logic port, input logic [31:0] addr, input logic [7:0] len, input string tag);
        if (port) begin
            req1_valid = 1'b1; req1_addr = addr; req1_len = len;
        end else begin
            req0_valid = 1'b1; req0_addr = addr; req0_len = len;
        end
        #1;
        checkOutput({tag, "_ready"}, port ? req1_ready : req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_last   = port;
        exp_q.push_back(port);
        checkOutput({tag, "_arvalid"}, M_AXI_ARVALID, 1);
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
    endtask

    // Full table transaction: request, AR checks with one cycle of ARREADY
    // back-pressure, burst return, then completion state.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.port) begin
            req1_valid = 1'b1; req1_addr = v.addr; req1_len = v.len;
        end else begin
            req0_valid = 1'b1; req0_addr = v.addr; req0_len = v.len;
        end
        #1;
        checkOutput({tag, "_ready"},       v.port ? req1_ready : req0_ready, 1);
        checkOutput({tag, "_other_ready"}, v.port ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_last   = v.port;
        checkOutput({tag, "_arvalid"},  M_AXI_ARVALID, 1);
        checkOutput({tag, "_araddr"},   M_AXI_ARADDR,  v.exp_addr);
        checkOutput({tag, "_arlen"},    M_AXI_ARLEN,   v.exp_len);
        checkOutput({tag, "_arsize"},   M_AXI_ARSIZE,  5);
        checkOutput({tag, "_arburst"},  M_AXI_ARBURST, 1);
        checkOutput({tag, "_arid"},     M_AXI_ARID,    0);
        checkOutput({tag, "_outst1"},   outstanding,   1);
        checkOutput({tag, "_busy"},     idle,          0);
        checkOutput({tag, "_noready"},  v.port ? req1_ready : req0_ready, 0);
        tick();
        checkOutput({tag, "_arvalid_hold"}, M_AXI_ARVALID, 1);
        checkOutput({tag, "_araddr_hold"},  M_AXI_ARADDR,  v.exp_addr);
        M_AXI_ARREADY = 1'b1;
        tick();
        M_AXI_ARREADY = 1'b0;
        checkOutput({tag, "_arvalid_done"}, M_AXI_ARVALID, 0);
        serveBurst(v.port, v.len, v.resp, tag);
        checkOutput({tag, "_outst0"}, outstanding, 0);
        checkOutput({tag, "_idle"},   idle,        1);
        checkOutput({tag, "_rd_err"}, rd_err,      v.exp_err);
    endtask

    initial begin
        vecs[0] = '{port: 1'b0, addr: 32'h0000_1000, len: 8'd255, resp: 2'b00, exp_addr: 32'h0000_1000, exp_len: 8'd255, exp_err: 1'b0};
        vecs[1] = '{port: 1'b1, addr: 32'h0000_2013, len: 8'd3,   resp: 2'b00, exp_addr: 32'h0000_2000, exp_len: 8'd3,   exp_err: 1'b0};
        vecs[2] = '{port: 1'b0, addr: 32'hFFFF_FFFF, len: 8'd0,   resp: 2'b00, exp_addr: 32'hFFFF_FFE0, exp_len: 8'd0,   exp_err: 1'b0};
        vecs[3] = '{port: 1'b1, addr: 32'h0000_0040, len: 8'd1,   resp: 2'b10, exp_addr: 32'h0000_0040, exp_len: 8'd1,   exp_err: 1'b1};
        vecs[4] = '{port: 1'b0, addr: 32'h0000_0055, len: 8'd2,   resp: 2'b00, exp_addr: 32'h0000_0040, exp_len: 8'd2,   exp_err: 1'b1};

        ARESETN       = 1'b0;
        req0_valid    = 1'b0; req0_addr = '0; req0_len = '0;
        req1_valid    = 1'b0; req1_addr = '0; req1_len = '0;
        rd0_ready     = 1'b1;
        rd1_ready     = 1'b1;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        M_AXI_RLAST   = 1'b0;
        M_AXI_RVALID  = 1'b0;
        err_clr       = 1'b0;
        exp_last      = 1'b1;

        // Reset state.
        #1;
        checkOutput("rst_arvalid", M_AXI_ARVALID, 0);
        checkOutput("rst_araddr",  M_AXI_ARADDR,  0);
        checkOutput("rst_arlen",   M_AXI_ARLEN,   0);
        checkOutput("rst_outst",   outstanding,   0);
        checkOutput("rst_rd_err",  rd_err,        0);
        checkOutput("rst_idle",    idle,          1);
        checkOutput("rst_rd0_val", rd0_valid,     0);
        checkOutput("rst_rd1_val", rd1_valid,     0);
        checkOutput("rst_rready",  M_AXI_RREADY,  0);
        tick();
        tick();
        ARESETN = 1'b1;
        tick();

        // Directed single-burst vectors.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Clear the sticky error left by the table.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("err_clr", rd_err, 0);

        // Both ports request continuously: grants alternate, the tag FIFO
        // fills to its limit, and a new request is only taken the cycle after
        // the first burst completes.
        req0_addr     = 32'h0000_0100; req0_len = 8'd3;
        req1_addr     = 32'h0000_0200; req1_len = 8'd3;
        M_AXI_ARREADY = 1'b1;
        for (int r = 0; r < 2; r++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            while (exp_q.size() < MAX_OUTSTANDING) begin
                #1;
                g = expGrant();
                checkOutput($sformatf("rr%0d_ready0", r), req0_ready, !g);
                checkOutput($sformatf("rr%0d_ready1", r), req1_ready, g);
                tick();
                exp_last = g;
                exp_q.push_back(g);
                checkOutput($sformatf("rr%0d_arvalid", r), M_AXI_ARVALID, 1);
                checkOutput($sformatf("rr%0d_araddr", r), M_AXI_ARADDR, g ? 32'h200 : 32'h100);
                tick();
            end
            for (int c = 0; c < 2; c++) begin
                #1;
                checkOutput("full_ready0", req0_ready, 0);
                checkOutput("full_ready1", req1_ready, 0);
                checkOutput("full_outst",  outstanding, MAX_OUTSTANDING);
                tick();
            end
            g = exp_q.pop_front();
            serveBurst(g, 8'd3, 2'b00, $sformatf("rr%0d_first", r));
            #1;
            g = expGrant();
            checkOutput("refill_ready0", req0_ready, !g);
            checkOutput("refill_ready1", req1_ready, g);
            checkOutput("refill_outst",  outstanding, MAX_OUTSTANDING - 1);
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            exp_last   = g;
            exp_q.push_back(g);
            checkOutput("refill_arvalid", M_AXI_ARVALID, 1);
            tick();
            checkOutput("refill_outst4", outstanding, MAX_OUTSTANDING);
            while (exp_q.size() > 0) begin
                g = exp_q.pop_front();
                serveBurst(g, 8'd3, 2'b00, $sformatf("rr%0d_drain", r));
            end
            checkOutput("rr_idle", idle, 1);
        end
        M_AXI_ARREADY = 1'b0;

        // rd1 stalls for 10 cycles in the middle of a burst.
        issueOne(1'b1, 32'h0000_3000, 8'd7, "bp_req");
        void'(exp_q.pop_front());
        for (int b = 0; b < 8; b++) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = beatData(1'b1, b);
            M_AXI_RLAST  = (b == 7);
            if (b == 4) begin
                rd1_ready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    #1;
                    checkOutput("bp_rready",   M_AXI_RREADY, 0);
                    checkOutput("bp_rd1_val",  rd1_valid,    1);
                    checkOutput("bp_rd1_data", rd1_data,     beatData(1'b1, 4));
                    checkOutput("bp_rd0_val",  rd0_valid,    0);
                    checkOutput("bp_outst",    outstanding,  1);
                    tick();
                end
                rd1_ready = 1'b1;
            end
            #1;
            checkOutput("bp_beat_val",  rd1_valid,    1);
            checkOutput("bp_beat_data", rd1_data,     beatData(1'b1, b));
            checkOutput("bp_beat_last", rd1_last,     b == 7);
            checkOutput("bp_beat_rdy",  M_AXI_RREADY, 1);
            tick();
        end
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        checkOutput("bp_done_outst", outstanding, 0);

        // Stray beat with nothing outstanding, then set-versus-clear priority.
        M_AXI_RVALID = 1'b1;
        M_AXI_RLAST  = 1'b1;
        M_AXI_RDATA  = beatData(1'b0, 77);
        #1;
        checkOutput("stray_rready", M_AXI_RREADY, 0);
        checkOutput("stray_rd0",    rd0_valid,    0);
        checkOutput("stray_rd1",    rd1_valid,    0);
        tick();
        checkOutput("stray_err",    rd_err,       1);
        checkOutput("stray_outst",  outstanding,  0);
        err_clr = 1'b1;
        tick();
        checkOutput("set_wins", rd_err, 1);
        M_AXI_RVALID = 1'b0;
        M_AXI_RLAST  = 1'b0;
        tick();
        err_clr = 1'b0;
        checkOutput("stray_clr", rd_err, 0);

        // Asynchronous reset with three bursts outstanding mid-beat.
        issueOne(1'b0, 32'h0000_0400, 8'd3, "rst_a");
        issueOne(1'b1, 32'h0000_0500, 8'd3, "rst_b");
        issueOne(1'b0, 32'h0000_0600, 8'd3, "rst_c");
        checkOutput("pre_rst_outst", outstanding, 3);
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = beatData(1'b0, 0);
        #1;
        checkOutput("pre_rst_rd0", rd0_valid, 1);
        tick();
        M_AXI_RDATA = beatData(1'b0, 1);
        #1;
        ARESETN = 1'b0;
        #1;
        checkOutput("mid_rst_outst",   outstanding,   0);
        checkOutput("mid_rst_idle",    idle,          1);
        checkOutput("mid_rst_arvalid", M_AXI_ARVALID, 0);
        checkOutput("mid_rst_araddr",  M_AXI_ARADDR,  0);
        checkOutput("mid_rst_arlen",   M_AXI_ARLEN,   0);
        checkOutput("mid_rst_rd_err",  rd_err,        0);
        checkOutput("mid_rst_rd0",     rd0_valid,     0);
        checkOutput("mid_rst_rd1",     rd1_valid,     0);
        checkOutput("mid_rst_rready",  M_AXI_RREADY,  0);
        M_AXI_RVALID = 1'b0;
        exp_q.delete();
        exp_last = 1'b1;
        tick();
        ARESETN = 1'b1;
        tick();
        applyStimulus(vecs[1], 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
